msgpass_buff_wr_arbiter: RTL and testbench
==========================================

// Module: msgpass_buff_wr_arbiter
// PURPOSE
//  Shares the two write ports (A/B) of the message-passing buffer among NUM_REQ
//  message producers (CNU/VNU update lanes) in the layered LDPC decoder.
//  Grants up to two writes per cycle using a round-robin pointer.
//  Never issues two same-cycle writes to one address.
//  Drives registered write-port signals and keeps an accepted-write counter.
// PARAMETERS
//  NUM_REQ  4                                          number of requesters (2..16)
//  DATA_W   msgPass_config_pkg::MSGPASS_BUFF_RDATA_WIDTH  write data width
//  ADDR_W   msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH   write address width
//  CNT_W    16                                         width of wr_count_o
// PORTS
//  clk_i          in   1               single clock; all logic rising-edge
//  rst            in   1               synchronous, active-high reset
//  stall_i        in   1               1 = block all grants this cycle
//  req_valid_i    in   NUM_REQ         per-requester write request
//  req_addr_i     in   NUM_REQ*ADDR_W  per-requester address, packed, req0 at LSBs
//  req_data_i     in   NUM_REQ*DATA_W  per-requester data, packed, req0 at LSBs
//  req_ready_o    out  NUM_REQ         grant; transfer = valid & ready, same cycle
//  wen_portA_o    out  1               port A write enable (registered)
//  waddr_portA_o  out  ADDR_W          port A write address
//  wdata_portA_o  out  DATA_W          port A write data
//  wen_portB_o    out  1               port B write enable (registered)
//  waddr_portB_o  out  ADDR_W          port B write address
//  wdata_portB_o  out  DATA_W          port B write data
//  wr_count_o     out  CNT_W           total accepted writes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (rst=1 at a clock edge): wen_*=0, waddr_*/wdata_*=0, wr_count_o=0, ptr=0.
//    req_ready_o is forced to 0 combinationally while rst=1, so no transfer is lost.
//  - Grant selection is combinational in the same cycle. Scan indices ptr, ptr+1, ...
//    modulo NUM_REQ:
//    - first valid index -> slot A;
//    - next valid index whose addr != slot-A addr -> slot B;
//    - a valid index with the same addr as slot A is skipped; it gets no ready this cycle.
//  - req_ready_o[i]=1 only for the slot-A/B indices, and only if !stall_i and !rst.
//    - A requester must not make valid depend on ready.
//    - Valid, addr and data must stay stable until ready.
//  - Latency: 1 cycle. A grant at edge N drives wen/waddr/wdata at edge N+1.
//  - With no slot-A grant: wen_portA_o=0 next cycle; waddr_portA_o/wdata_portA_o
//    hold their values. Port B follows the same rule.
//  - Only one grant in a cycle: it always goes to port A.
//  - Pointer update:
//    - after any cycle with >=1 grant, ptr <= (highest-priority-order granted
//      index + 1) mod NUM_REQ, i.e. one past the slot-B index, else one past the
//      slot-A index;
//    - no grants (idle or stall_i) -> ptr unchanged.
//  - wr_count_o += popcount(grants), 0..2 per cycle; wraps from all-ones without a flag.
//  - stall_i=1: zero grants; wen_* = 0 on the next edge; pointer and counter hold.
//  - Fairness: a requester that stays valid is granted within ceil(NUM_REQ/2)+1
//    grant cycles. Exception: its address collides every cycle, in which case the
//    rotating pointer makes it slot A within NUM_REQ grant cycles.
//  - rst while requests are pending: outputs clear on that edge. Requesters simply
//    retry, since none saw ready=1.
// STRUCTURE
//  - msgPass_config_pkg: MSGPASS_BUFF_RDATA_WIDTH and MSGPASS_BUFF_ADDR_WIDTH
//    (already there). Add:
//    - MSGPASS_WR_NUM_REQ;
//    - typedef msgpass_wr_req_t {addr, data};
//    - typedef msgpass_wr_port_t {wen, addr, data}.
//  - Sub-module msgpass_rr_dual_picker: purely combinational. Inputs: valid vector,
//    addresses, ptr. Outputs: one-hot grantA, one-hot grantB, next_ptr.
//    The top holds ptr, the output registers and the counter.
// TESTING
//  - Reset: rst=1 for 2 cycles with all valid=1 -> ready=0, wen_A/B=0, wr_count_o=0.
//  - Single write: req2 valid, addr=0x05, data=0xAA -> ready[2]=1 that cycle;
//    next cycle wen_A=1, waddr_A=0x05, wdata_A=0xAA, wen_B=0, wr_count_o=1.
//  - Dual grant with ptr=0: req0 addr 3, req1 addr 7 -> A=(3,req0 data),
//    B=(7,req1 data); ptr=2; wr_count_o += 2.
//  - Collision with ptr=0: req0 and req1 both addr 9, req3 addr 4 -> A=req0, B=req3,
//    ready[1]=0. req1 is granted in the following cycle.
//  - Fairness: all 4 valid with distinct addrs for 4 cycles -> grant pairs
//    (0,1), (2,3), (0,1), (2,3).
//  - Stall/wrap: stall_i=1 for 3 cycles -> no ready, wen=0, ptr held. Then preload
//    count 0xFFFF with one write -> wr_count_o=0x0000.

Source files
------------

// File: rtl/msgPass_config_pkg.sv
// ---------------------------------------------------------------------------
// msgPass_config_pkg
// Shared configuration for the message-passing buffer of the layered LDPC
// decoder: buffer geometry, write-arbiter requester count, and the record
// types used for write requests and write-port drive.
// ---------------------------------------------------------------------------
package msgPass_config_pkg;

    localparam int unsigned MSGPASS_BUFF_RDATA_WIDTH = 16;
    localparam int unsigned MSGPASS_BUFF_ADDR_WIDTH  = 8;
    localparam int unsigned MSGPASS_WR_NUM_REQ       = 4;

    typedef struct packed {
        logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  addr;
        logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] data;
    } msgpass_wr_req_t;

    typedef struct packed {
        logic                                wen;
        logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  addr;
        logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] data;
    } msgpass_wr_port_t;

endpackage

// File: rtl/msgpass_rr_dual_picker.sv
// ---------------------------------------------------------------------------
// msgpass_rr_dual_picker
// Purely combinational round-robin picker for two write slots.
// Scans requesters starting at ptr_i: the first valid one takes slot A, the
// next valid one with a different address takes slot B. Requesters whose
// address equals slot A's are skipped for this cycle.
// Ports:
//   valid_i     [NUM_REQ]         request vector
//   addr_i      [NUM_REQ*ADDR_W]  packed addresses, req0 at LSBs
//   ptr_i       [PTR_W]           current round-robin start index
//   grantA_o    [NUM_REQ]         one-hot slot-A grant (or zero)
//   grantB_o    [NUM_REQ]         one-hot slot-B grant (or zero)
//   next_ptr_o  [PTR_W]           one past the last granted index in scan order
// ---------------------------------------------------------------------------
module msgpass_rr_dual_picker
    import msgPass_config_pkg::*;
#(
    parameter int unsigned NUM_REQ = MSGPASS_WR_NUM_REQ,
    parameter int unsigned ADDR_W  = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]        valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [PTR_W-1:0]          ptr_i,
    output logic [NUM_REQ-1:0]        grantA_o,
    output logic [NUM_REQ-1:0]        grantB_o,
    output logic [PTR_W-1:0]          next_ptr_o
);

    always_comb begin
        logic              found_a;
        logic              found_b;
        logic [ADDR_W-1:0] addr_a;
        int unsigned       idx;
        found_a    = 1'b0;
        found_b    = 1'b0;
        addr_a     = '0;
        idx        = 0;
        grantA_o   = '0;
        grantB_o   = '0;
        next_ptr_o = ptr_i;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_i) + k) % NUM_REQ;
            if (valid_i[idx]) begin
                if (!found_a) begin
                    found_a       = 1'b1;
                    grantA_o[idx] = 1'b1;
                    addr_a        = addr_i[idx*ADDR_W +: ADDR_W];
                    next_ptr_o    = PTR_W'((idx + 1) % NUM_REQ);
                end else if (!found_b && (addr_i[idx*ADDR_W +: ADDR_W] != addr_a)) begin
                    // Slot B is always later in scan order, so it overrides next_ptr.
                    found_b       = 1'b1;
                    grantB_o[idx] = 1'b1;
                    next_ptr_o    = PTR_W'((idx + 1) % NUM_REQ);
                end
            end
        end
    end

endmodule

// File: rtl/msgpass_buff_wr_arbiter.sv
// ---------------------------------------------------------------------------
// msgpass_buff_wr_arbiter
// Shares the two write ports (A/B) of the message-passing buffer among
// NUM_REQ producers. Up to two grants per cycle, round-robin, never two
// writes to the same address in one cycle. Write ports are registered
// (1-cycle latency); wr_count_o counts accepted writes modulo 2^CNT_W.
// Ports:
//   clk_i, rst        clock, synchronous active-high reset
//   stall_i           blocks all grants this cycle
//   req_valid_i       per-requester write request
//   req_addr_i        packed addresses, req0 at LSBs
//   req_data_i        packed data, req0 at LSBs
//   req_ready_o       grant (transfer = valid & ready, same cycle)
//   wen/waddr/wdata_portA_o, wen/waddr/wdata_portB_o   registered write ports
//   wr_count_o        accepted-write counter
// ---------------------------------------------------------------------------
module msgpass_buff_wr_arbiter
    import msgPass_config_pkg::*;
#(
    parameter int unsigned NUM_REQ = MSGPASS_WR_NUM_REQ,
    parameter int unsigned DATA_W  = MSGPASS_BUFF_RDATA_WIDTH,
    parameter int unsigned ADDR_W  = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      wen_portA_o,
    output logic [ADDR_W-1:0]         waddr_portA_o,
    output logic [DATA_W-1:0]         wdata_portA_o,
    output logic                      wen_portB_o,
    output logic [ADDR_W-1:0]         waddr_portB_o,
    output logic [DATA_W-1:0]         wdata_portB_o,
    output logic [CNT_W-1:0]          wr_count_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_a, grant_b;
    logic               take_a, take_b;
    logic [ADDR_W-1:0]  addr_a, addr_b;
    logic [DATA_W-1:0]  data_a, data_b;

    logic               wen_a_q, wen_b_q;
    logic [ADDR_W-1:0]  addr_a_q, addr_b_q;
    logic [DATA_W-1:0]  data_a_q, data_b_q;
    logic [CNT_W-1:0]   count_q;

    msgpass_rr_dual_picker #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .PTR_W   (PTR_W)
    ) u_picker (
        .valid_i    (req_valid_i),
        .addr_i     (req_addr_i),
        .ptr_i      (ptr_q),
        .grantA_o   (grant_a),
        .grantB_o   (grant_b),
        .next_ptr_o (ptr_d)
    );

    // Ready is gated by rst as well so nothing is handed over during reset.
    assign take_a      = (|grant_a) & ~stall_i & ~rst;
    assign take_b      = (|grant_b) & ~stall_i & ~rst;
    assign req_ready_o = (stall_i | rst) ? '0 : (grant_a | grant_b);

    always_comb begin
        addr_a = '0;
        data_a = '0;
        addr_b = '0;
        data_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_a[i]) begin
                addr_a = req_addr_i[i*ADDR_W +: ADDR_W];
                data_a = req_data_i[i*DATA_W +: DATA_W];
            end
            if (grant_b[i]) begin
                addr_b = req_addr_i[i*ADDR_W +: ADDR_W];
                data_b = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            ptr_q    <= '0;
            wen_a_q  <= 1'b0;
            wen_b_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            count_q  <= '0;
        end else begin
            wen_a_q <= take_a;
            wen_b_q <= take_b;
            // Address/data hold when the port is not written.
            if (take_a) begin
                addr_a_q <= addr_a;
                data_a_q <= data_a;
            end
            if (take_b) begin
                addr_b_q <= addr_b;
                data_b_q <= data_b;
            end
            if (take_a) begin
                ptr_q <= ptr_d;
            end
            count_q <= count_q + CNT_W'(take_a) + CNT_W'(take_b);
        end
    end

    assign wen_portA_o   = wen_a_q;
    assign waddr_portA_o = addr_a_q;
    assign wdata_portA_o = data_a_q;
    assign wen_portB_o   = wen_b_q;
    assign waddr_portB_o = addr_b_q;
    assign wdata_portB_o = data_b_q;
    assign wr_count_o    = count_q;

endmodule

// File: tb/tb_msgpass_buff_wr_arbiter.sv
`timescale 1ns/1ps
module tb_msgpass_buff_wr_arbiter;
    import msgPass_config_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = MSGPASS_BUFF_ADDR_WIDTH;
    localparam int unsigned DW = MSGPASS_BUFF_RDATA_WIDTH;

    typedef struct {
        msgpass_wr_port_t a;
        msgpass_wr_port_t b;
        logic [15:0]      cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_i;
    logic [N-1:0]      req_valid_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*DW-1:0]   req_data_i;
    logic [N-1:0]      req_ready_o;
    logic              wen_portA_o, wen_portB_o;
    logic [AW-1:0]     waddr_portA_o, waddr_portB_o;
    logic [DW-1:0]     wdata_portA_o, wdata_portB_o;
    logic [15:0]       wr_count_o;

    logic [AW-1:0]     r_addr [N];
    logic [DW-1:0]     r_data [N];

    exp_t              q[$];
    msgpass_wr_port_t  hold_a, hold_b;
    logic [15:0]       exp_cnt;
    int                n_pass = 0;
    int                n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW] = r_addr[i];
            req_data_i[i*DW +: DW] = r_data[i];
        end
    end

    msgpass_buff_wr_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .CNT_W   (16)
    ) dut (
        .clk_i         (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .req_valid_i   (req_valid_i),
        .req_addr_i    (req_addr_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .wen_portA_o   (wen_portA_o),
        .waddr_portA_o (waddr_portA_o),
        .wdata_portA_o (wdata_portA_o),
        .wen_portB_o   (wen_portB_o),
        .waddr_portB_o (waddr_portB_o),
        .wdata_portB_o (wdata_portB_o),
        .wr_count_o    (wr_count_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    // Monitor: one registered-output snapshot per pushed expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("portA", {wen_portA_o, waddr_portA_o, wdata_portA_o}, e.a);
                chk("portB", {wen_portB_o, waddr_portB_o, wdata_portB_o}, e.b);
                chk("wr_count", wr_count_o, e.cnt);
            end
        end
    end

    // Drive one cycle. ia/ib: requester index expected on port A/B, -1 if none.
    task automatic step(input logic stall, input logic [N-1:0] v,
                        input logic [N-1:0] exp_rdy, input int ia, input int ib);
        exp_t e;
        stall_i     = stall;
        req_valid_i = v;
        @(negedge clk);
        chk("ready", req_ready_o, exp_rdy);
        hold_a.wen = 1'b0;
        hold_b.wen = 1'b0;
        if (ia >= 0) begin
            hold_a.wen  = 1'b1;
            hold_a.addr = r_addr[ia];
            hold_a.data = r_data[ia];
            exp_cnt++;
        end
        if (ib >= 0) begin
            hold_b.wen  = 1'b1;
            hold_b.addr = r_addr[ib];
            hold_b.data = r_data[ib];
            exp_cnt++;
        end
        e.a = hold_a;
        e.b = hold_b;
        e.cnt = exp_cnt;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        stall_i = 1'b0;
        req_valid_i = '1;
        for (int i = 0; i < N; i++) begin
            r_addr[i] = AW'(i + 1);
            r_data[i] = DW'(16'h0100 + i);
        end
        hold_a  = '0;
        hold_b  = '0;
        exp_cnt = '0;
        @(posedge clk);
        #2;

        // Reset with all requesters valid.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ready_in_reset", req_ready_o, 4'b0000);
            e.a = '0;
            e.b = '0;
            e.cnt = '0;
            q.push_back(e);
            @(posedge clk);
            #2;
        end
        rst = 1'b0;

        // Single write from req2 (ptr 0 -> 3).
        r_addr[2] = 8'h05; r_data[2] = 16'h00AA;
        step(1'b0, 4'b0100, 4'b0100, 2, -1);
        // req3 alone brings ptr back to 0.
        r_addr[3] = 8'h11; r_data[3] = 16'h0033;
        step(1'b0, 4'b1000, 4'b1000, 3, -1);
        // Dual grant at ptr 0 (-> ptr 2).
        r_addr[0] = 8'h03; r_data[0] = 16'h1111;
        r_addr[1] = 8'h07; r_data[1] = 16'h2222;
        step(1'b0, 4'b0011, 4'b0011, 0, 1);
        // req3 alone: ptr 2 -> 0; port B holds previous values.
        r_addr[3] = 8'h20; r_data[3] = 16'h0044;
        step(1'b0, 4'b1000, 4'b1000, 3, -1);
        // Collision: req0/req1 share addr 9; req1 skipped, req3 takes B (ptr -> 0).
        r_addr[0] = 8'h09; r_data[0] = 16'h00A0;
        r_addr[1] = 8'h09; r_data[1] = 16'h00A1;
        r_addr[3] = 8'h04; r_data[3] = 16'h00A3;
        step(1'b0, 4'b1011, 4'b1001, 0, 3);
        // req1 retries and wins slot A (ptr -> 2).
        step(1'b0, 4'b0010, 4'b0010, 1, -1);
        // req3 alone: ptr 2 -> 0.
        r_addr[3] = 8'h21; r_data[3] = 16'h0055;
        step(1'b0, 4'b1000, 4'b1000, 3, -1);

        // Fairness: all valid, distinct addresses.
        for (int i = 0; i < N; i++) begin
            r_addr[i] = AW'(8'h30 + i);
            r_data[i] = DW'(16'h00B0 + i);
        end
        step(1'b0, 4'b1111, 4'b0011, 0, 1);
        step(1'b0, 4'b1111, 4'b1100, 2, 3);
        step(1'b0, 4'b1111, 4'b0011, 0, 1);
        step(1'b0, 4'b1111, 4'b1100, 2, 3);

        // Stall: no grants, pointer (0) and counter hold.
        step(1'b1, 4'b1111, 4'b0000, -1, -1);
        step(1'b1, 4'b1111, 4'b0000, -1, -1);
        step(1'b1, 4'b1111, 4'b0000, -1, -1);
        step(1'b0, 4'b1111, 4'b0011, 0, 1);

        // Run the counter up to 0xFFFF with dual writes (ptr stays 2).
        r_addr[0] = 8'h40; r_data[0] = 16'h5A5A;
        r_addr[1] = 8'h41; r_data[1] = 16'hA5A5;
        while (int'(exp_cnt) <= 16'hFFFD) step(1'b0, 4'b0011, 4'b0011, 0, 1);
        if (exp_cnt != 16'hFFFF) step(1'b0, 4'b0001, 4'b0001, 0, -1);
        // One more write wraps to zero.
        step(1'b0, 4'b0010, 4'b0010, 1, -1);

        req_valid_i = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
